// File: rtl/mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_stage: RV32I MEM stage, data-bus loads/stores and MEM/WB reg.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_mem_valid,
   input  logic [DATA_WIDTH-1:0] ex_mem_alu_result,
   input  logic [DATA_WIDTH-1:0] ex_mem_rs2_data,
   input  logic [DATA_WIDTH-1:0] ex_mem_PC_plus_4,
   input  logic [2:0]            ex_mem_funct3,
   input  logic                  ex_mem_MemRead,
   input  logic                  ex_mem_MemWrite,
   input  logic                  ex_mem_RegWrite,
   input  logic [1:0]            ex_mem_wb_sel,
   input  logic [4:0]            ex_mem_rd,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic [3:0]            dmem_be,
   input  logic                  dmem_ready,
   input  logic                  dmem_rvalid,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  mem_stall,
   output logic                  mem_wb_valid,
   output logic                  mem_wb_RegWrite,
   output logic [4:0]            mem_wb_rd,
   output logic [DATA_WIDTH-1:0] mem_wb_write_data,
   output logic                  mem_exc,
   output logic                  bus_err
);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_req  = 2'd1;
   localparam logic [1:0] c_st_resp = 2'd2;

   localparam int              c_cnt_w    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic            c_wdog_en  = (TIMEOUT_CYCLES > 0);

   logic [1:0]            r_state;
   logic [1:0]            w_next;
   logic [c_cnt_w-1:0]    r_cnt;
   logic [1:0]            w_a;
   logic                  w_store;
   logic                  w_memop;
   logic                  w_bad;
   logic                  w_req;
   logic                  w_done;
   logic                  w_tmo;
   logic                  w_err;
   logic                  w_exc;
   logic [DATA_WIDTH-1:0] w_lane;
   logic [DATA_WIDTH-1:0] w_load_data;
   logic [DATA_WIDTH-1:0] w_wb_data;

   assign w_a     = ex_mem_alu_result[1:0];
   assign w_store = ex_mem_MemWrite;
   assign w_memop = ex_mem_valid & (ex_mem_MemRead | ex_mem_MemWrite);

   always_comb begin
      w_bad = 1'b0;
      if (w_store)
         w_bad = (ex_mem_funct3 > 3'b010);
      else
         w_bad = (ex_mem_funct3 == 3'b011) | (ex_mem_funct3 == 3'b110) | (ex_mem_funct3 == 3'b111);
      if ((ex_mem_funct3[1:0] == 2'b01) && w_a[0])
         w_bad = 1'b1;
      if ((ex_mem_funct3[1:0] == 2'b10) && (w_a != 2'b00))
         w_bad = 1'b1;
   end

   assign dmem_addr = {ex_mem_alu_result[ADDR_WIDTH-1:2], 2'b00};
   assign dmem_we   = ex_mem_valid & w_store;

   always_comb begin
      dmem_be    = 4'b0000;
      dmem_wdata = ex_mem_rs2_data;
      case (ex_mem_funct3[1:0])
         2'b00: begin
            dmem_be    = 4'b0001 << w_a;
            dmem_wdata = {4{ex_mem_rs2_data[7:0]}};
         end
         2'b01: begin
            dmem_be    = 4'b0011 << w_a;
            dmem_wdata = {2{ex_mem_rs2_data[15:0]}};
         end
         default: dmem_be = 4'b1111;
      endcase
      if (!w_store)
         dmem_be = 4'b0000;
   end

   assign w_lane = dmem_rdata >> {w_a, 3'b000};

   always_comb begin
      case (ex_mem_funct3)
         3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
         3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
         3'b100:  w_load_data = {24'd0, w_lane[7:0]};
         3'b101:  w_load_data = {16'd0, w_lane[15:0]};
         default: w_load_data = dmem_rdata;
      endcase
   end

   always_comb begin
      case (ex_mem_wb_sel)
         2'b01:   w_wb_data = w_load_data;
         2'b10:   w_wb_data = ex_mem_PC_plus_4;
         default: w_wb_data = ex_mem_alu_result;
      endcase
   end

   // The watchdog fires on the TIMEOUT_CYCLES-th cycle spent in REQ/RESP.
   assign w_tmo = c_wdog_en && (r_state != c_st_idle) && (r_cnt == c_tmo_last);

   always_comb begin
      w_next = r_state;
      w_req  = 1'b0;
      w_done = 1'b0;
      w_err  = 1'b0;
      case (r_state)
         c_st_idle: begin
            if (ex_mem_valid) begin
               if (!w_memop || w_bad) begin
                  w_done = 1'b1;
               end else begin
                  w_req = 1'b1;
                  if (dmem_ready && w_store)
                     w_done = 1'b1;
                  else if (dmem_ready)
                     w_next = c_st_resp;
                  else
                     w_next = c_st_req;
               end
            end
         end
         c_st_req: begin
            w_req = 1'b1;
            if (dmem_ready && w_store) begin
               w_done = 1'b1;
               w_next = c_st_idle;
            end else if (w_tmo) begin
               w_done = 1'b1;
               w_err  = 1'b1;
               w_next = c_st_idle;
            end else if (dmem_ready) begin
               w_next = c_st_resp;
            end
         end
         c_st_resp: begin
            if (dmem_rvalid) begin
               w_done = 1'b1;
               w_next = c_st_idle;
            end else if (w_tmo) begin
               w_done = 1'b1;
               w_err  = 1'b1;
               w_next = c_st_idle;
            end
         end
         default: w_next = c_st_idle;
      endcase
   end

   assign w_exc     = (r_state == c_st_idle) & w_memop & w_bad;
   assign dmem_req  = w_req & rst_n;
   assign mem_stall = ex_mem_valid & ~w_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state           <= c_st_idle;
         r_cnt             <= '0;
         mem_wb_valid      <= 1'b0;
         mem_wb_RegWrite   <= 1'b0;
         mem_wb_rd         <= 5'd0;
         mem_wb_write_data <= '0;
         mem_exc           <= 1'b0;
         bus_err           <= 1'b0;
      end else begin
         r_state         <= w_next;
         r_cnt           <= (r_state == c_st_idle) ? '0 : r_cnt + c_cnt_w'(1);
         mem_wb_valid    <= w_done;
         mem_wb_RegWrite <= w_done & ex_mem_RegWrite & ~w_exc & ~w_err;
         mem_exc         <= w_done & w_exc;
         bus_err         <= w_err;
         if (w_done) begin
            mem_wb_rd         <= ex_mem_rd;
            mem_wb_write_data <= w_wb_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_stage: random and directed stimulus with a WB scoreboard.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_access_stage;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_mem_valid = 1'b0;
   logic [31:0] ex_mem_alu_result = '0;
   logic [31:0] ex_mem_rs2_data = '0;
   logic [31:0] ex_mem_PC_plus_4 = '0;
   logic [2:0]  ex_mem_funct3 = '0;
   logic        ex_mem_MemRead = 1'b0;
   logic        ex_mem_MemWrite = 1'b0;
   logic        ex_mem_RegWrite = 1'b0;
   logic [1:0]  ex_mem_wb_sel = '0;
   logic [4:0]  ex_mem_rd = '0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        mem_stall, mem_wb_valid, mem_wb_RegWrite, mem_exc, bus_err;
   logic [4:0]  mem_wb_rd;
   logic [31:0] mem_wb_write_data;

   mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .ex_mem_valid(ex_mem_valid),
      .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_rs2_data(ex_mem_rs2_data),
      .ex_mem_PC_plus_4(ex_mem_PC_plus_4), .ex_mem_funct3(ex_mem_funct3),
      .ex_mem_MemRead(ex_mem_MemRead), .ex_mem_MemWrite(ex_mem_MemWrite),
      .ex_mem_RegWrite(ex_mem_RegWrite), .ex_mem_wb_sel(ex_mem_wb_sel), .ex_mem_rd(ex_mem_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .mem_stall(mem_stall), .mem_wb_valid(mem_wb_valid), .mem_wb_RegWrite(mem_wb_RegWrite),
      .mem_wb_rd(mem_wb_rd), .mem_wb_write_data(mem_wb_write_data), .mem_exc(mem_exc), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        regwrite;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        chk_data;
      logic        exc;
      logic        berr;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad_cnt++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every MEM/WB output is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (mem_wb_valid) begin
            chk("wb_has_expectation", 32'(mem_wb_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("wb_regwrite", 32'(mem_wb_RegWrite), 32'(e.regwrite));
               chk("wb_rd", 32'(mem_wb_rd), 32'(e.rd));
               chk("wb_exc", 32'(mem_exc), 32'(e.exc));
               chk("wb_bus_err", 32'(bus_err), 32'(e.berr));
               if (e.chk_data)
                  chk("wb_data", mem_wb_write_data, e.data);
            end
         end else begin
            chk("bubble_pulses", {30'd0, mem_exc, bus_err}, 32'd0);
         end
      end
   end

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
      logic [31:0] v;
      v = word >> ((a % 4) * 8);
      case (f3)
         3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
         3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
         3'd4: v = v % 256;
         3'd5: v = v % 65536;
         default: v = word;
      endcase
      return v;
   endfunction

   task automatic idle_cycle();
      ex_mem_valid    = 1'b0;
      ex_mem_MemRead  = 1'($urandom);
      ex_mem_MemWrite = 1'($urandom);
      dmem_ready      = 1'b0;
      dmem_rvalid     = 1'b0;
      @(negedge clk);
      chk("idle_stall", 32'(mem_stall), 32'd0);
      chk("idle_req", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
   endtask

   // One instruction; ready comes w cycles after presentation, rvalid r cycles after acceptance.
   task automatic issue(input logic [2:0] f3, input logic rd_en, input logic wr_en,
                        input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4,
                        input logic [1:0] wb_sel, input logic regw, input logic [4:0] rd,
                        input int w, input int r, input logic [31:0] rword);
      exp_t        e;
      logic        memop, illegal, bad, tmo;
      int          size, done_cycle, req_last;
      logic [31:0] data, ebe, ewd;
      memop   = rd_en | wr_en;
      size    = 1 << f3[1:0];
      illegal = wr_en ? (f3 > 2) : (rd_en ? (f3 == 3 || f3 == 6 || f3 == 7) : 1'b0);
      bad     = memop && (illegal || (alu % size) != 0);
      if (!memop || bad) done_cycle = 0;
      else if (wr_en)    done_cycle = w;
      else               done_cycle = w + 1 + r;
      tmo = memop && !bad && done_cycle > T;
      if (tmo) done_cycle = T;
      req_last = (memop && !bad) ? ((w < done_cycle) ? w : done_cycle) : -1;
      case (wb_sel)
         2'd1:    data = load_val(f3, alu, rword);
         2'd2:    data = pc4;
         default: data = alu;
      endcase
      ebe = wr_en ? (((32'd1 << size) - 1) << (alu % 4)) : 32'd0;
      ewd = (f3[1:0] == 0) ? (rs2 % 256) * 32'h01010101 :
            (f3[1:0] == 1) ? (rs2 % 65536) * 32'h00010001 : rs2;
      e.regwrite = regw && !bad && !tmo;
      e.rd       = rd;
      e.data     = data;
      e.chk_data = !(wb_sel == 2'd1 && (bad || tmo));
      e.exc      = bad;
      e.berr     = tmo;
      q.push_back(e);

      ex_mem_valid = 1'b1;   ex_mem_funct3 = f3;
      ex_mem_MemRead = rd_en; ex_mem_MemWrite = wr_en;
      ex_mem_alu_result = alu; ex_mem_rs2_data = rs2; ex_mem_PC_plus_4 = pc4;
      ex_mem_wb_sel = wb_sel; ex_mem_RegWrite = regw; ex_mem_rd = rd;
      for (int k = 0; k <= done_cycle; k++) begin
         dmem_ready = memop && !bad && (k == w);
         if (rd_en && !bad && (k == w + 1 + r)) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rword;
         end else begin
            dmem_rvalid = (k <= w) && ($urandom_range(3) == 0);
            dmem_rdata  = $urandom;
         end
         @(negedge clk);
         chk("stall", 32'(mem_stall), 32'(k < done_cycle));
         chk("req", 32'(dmem_req), 32'(k <= req_last));
         if (k == 0 && memop && !bad) begin
            chk("addr", dmem_addr, {alu[31:2], 2'b00});
            chk("we", 32'(dmem_we), 32'(wr_en));
            chk("be", 32'(dmem_be), ebe);
            if (wr_en) chk("wdata", dmem_wdata, ewd);
         end
         @(posedge clk); #1;
      end
      ex_mem_valid = 1'b0;
      dmem_ready   = 1'b0;
      dmem_rvalid  = 1'b0;
   endtask

   task automatic check_regs_zero(input string tag);
      chk({tag, "_wb_valid"}, 32'(mem_wb_valid), 32'd0);
      chk({tag, "_regwrite"}, 32'(mem_wb_RegWrite), 32'd0);
      chk({tag, "_rd"}, 32'(mem_wb_rd), 32'd0);
      chk({tag, "_data"}, mem_wb_write_data, 32'd0);
      chk({tag, "_pulses"}, {30'd0, mem_exc, bus_err}, 32'd0);
      chk({tag, "_req"}, 32'(dmem_req), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int kind, w, r;
      logic [2:0] f3;
      logic [1:0] sel;
      ex_mem_valid = 1'b1; ex_mem_MemRead = 1'b1;
      repeat (2) @(negedge clk);
      check_regs_zero("reset");
      ex_mem_valid = 1'b0; ex_mem_MemRead = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(3'd0, 0, 0, 32'h1234, 32'h0, 32'h4, 2'd0, 1, 5'd5, 0, 0, 32'h0);
      issue(3'd2, 0, 1, 32'h100, 32'hDEADBEEF, 32'h8, 2'd0, 0, 5'd0, 0, 0, 32'h0);
      issue(3'd1, 0, 1, 32'h102, 32'h0000ABCD, 32'hC, 2'd0, 0, 5'd0, 0, 0, 32'h0);
      issue(3'd0, 1, 0, 32'h103, 32'h0, 32'h10, 2'd1, 1, 5'd7, 2, 0, 32'h80FFFF00);
      issue(3'd4, 1, 0, 32'h103, 32'h0, 32'h14, 2'd1, 1, 5'd8, 2, 0, 32'h80FFFF00);
      issue(3'd2, 1, 0, 32'h102, 32'h0, 32'h18, 2'd1, 1, 5'd9, 0, 0, 32'h0);
      issue(3'd2, 1, 0, 32'h200, 32'h0, 32'h1C, 2'd1, 1, 5'd10, 100, 0, 32'h0);
      issue(3'd2, 0, 1, 32'h204, 32'h55, 32'h20, 2'd2, 1, 5'd11, 100, 0, 32'h0);
      issue(3'd1, 1, 0, 32'h206, 32'h0, 32'h24, 2'd1, 1, 5'd12, 0, 100, 32'h0);
      issue(3'd2, 0, 1, 32'h208, 32'h1, 32'h28, 2'd3, 1, 5'd13, T, 0, 32'h0);

      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(3);
         f3   = 3'($urandom);
         w    = $urandom_range(3);
         r    = $urandom_range(3);
         if ($urandom_range(15) == 0) w = 20;
         if ($urandom_range(15) == 0) r = 20;
         sel = 2'($urandom);
         if (sel == 2'd1) sel = 2'd2;
         if (kind == 0)
            issue(f3, 0, 0, $urandom, $urandom, $urandom, sel, 1'($urandom), 5'($urandom), 0, 0, 32'h0);
         else if (kind == 1 || kind == 3)
            issue(f3, 1, 0, $urandom, $urandom, $urandom, 2'd1, 1'($urandom), 5'($urandom), w, r, $urandom);
         else
            issue(f3, 0, 1, $urandom, $urandom, $urandom, sel, 1'b0, 5'($urandom), w, 0, 32'h0);
         if ($urandom_range(3) == 0) idle_cycle();
      end

      idle_cycle();
      idle_cycle();
      chk("drained_before_reset", 32'(q.size()), 32'd0);
      // Abandon a load in RESP through reset; its late rvalid must be ignored.
      ex_mem_valid = 1'b1; ex_mem_MemRead = 1'b1; ex_mem_MemWrite = 1'b0;
      ex_mem_funct3 = 3'd2; ex_mem_alu_result = 32'h300; ex_mem_wb_sel = 2'd1;
      ex_mem_RegWrite = 1'b1; ex_mem_rd = 5'd3; dmem_ready = 1'b1;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check_regs_zero("mid_reset");
      ex_mem_valid = 1'b0; ex_mem_MemRead = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("late_rvalid_stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      @(negedge clk);
      chk("late_rvalid_ignored", 32'(mem_wb_valid), 32'd0);
      @(posedge clk); #1;
      issue(3'd5, 1, 0, 32'h302, 32'h0, 32'h0, 2'd1, 1, 5'd4, 1, 1, 32'h9ABC1234);
      issue(3'd0, 0, 0, 32'h77, 32'h0, 32'h88, 2'd2, 1, 5'd6, 0, 0, 32'h0);

      repeat (3) idle_cycle();
      chk("pending_wb", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad_cnt);
      $finish;
   end

endmodule
`default_nettype wire
